// File: rtl/adder_rr_arbiter_if.sv
// Requester-side bundle for adder_rr_arbiter: request operands, grant and completion strobes.
// The arbiter attaches to the slave modport and the client side to the master modport.
interface adder_rr_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 4
);
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ*WIDTH-1:0] req_a;
   logic [NUM_REQ*WIDTH-1:0] req_b;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ-1:0]       resp_valid;
   logic [WIDTH-1:0]         resp_sum;
   logic                     resp_carry;

   modport slave (
      input  req_valid, req_a, req_b,
      output req_ready, resp_valid, resp_sum, resp_carry
   );

   modport master (
      output req_valid, req_a, req_b,
      input  req_ready, resp_valid, resp_sum, resp_carry
   );
endinterface

// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter sharing one 2-cycle registered adder among NUM_REQ requesters.
// Optional perf counters are built when ADDER_RR_ARB_PERF_EN is defined.
module adder_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               hold,
   adder_rr_arbiter_if.slave  cli,
   output logic [WIDTH-1:0]   add_a,
   output logic [WIDTH-1:0]   add_b,
   input  logic [WIDTH-1:0]   add_sum,
   input  logic               add_carry,
   output logic               idle,
   output logic [15:0]        perf_ops,
   output logic [15:0]        perf_wait
);

   localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

   // Handshake: a request transfers in the cycle req_valid[i] & req_ready[i] are both high;
   // req_ready is one-hot or zero and only ever raised on a valid requester. Responses have
   // no backpressure: resp_valid is a single-cycle strobe the requester must accept.

   logic [ID_W-1:0]    last_gnt;
   logic [ID_W-1:0]    gnt_id;
   logic               gnt_v;
   logic [NUM_REQ-1:0] gnt_oh;
   logic               s1_v;
   logic [ID_W-1:0]    s1_id;
   logic               s2_v;
   logic [ID_W-1:0]    s2_id;

   // Search starts one past the last winner and wraps, so every active requester is
   // reached within NUM_REQ grants.
   always_comb begin : arbitrate
      int              idx;
      logic [ID_W-1:0] idx_b;
      gnt_v = 1'b0;
      gnt_id = '0;
      idx = 0;
      idx_b = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = int'(last_gnt) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         idx_b = ID_W'(idx);
         if (!gnt_v && cli.req_valid[idx_b]) begin
            gnt_v = 1'b1;
            gnt_id = idx_b;
         end
      end
      if (hold || rst) begin
         gnt_v = 1'b0;
         gnt_id = '0;
      end
   end

   always_comb begin
      gnt_oh = '0;
      if (gnt_v) gnt_oh[gnt_id] = 1'b1;
   end

   assign cli.req_ready = gnt_oh;
   assign add_a = gnt_v ? cli.req_a[int'(gnt_id)*WIDTH +: WIDTH] : '0;
   assign add_b = gnt_v ? cli.req_b[int'(gnt_id)*WIDTH +: WIDTH] : '0;

   // Tag pipeline mirrors the adder's two register stages and never stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_gnt <= LAST_ID;
         s1_v     <= 1'b0;
         s1_id    <= '0;
         s2_v     <= 1'b0;
         s2_id    <= '0;
      end else begin
         if (gnt_v) last_gnt <= gnt_id;
         s1_v  <= gnt_v;
         s1_id <= gnt_id;
         s2_v  <= s1_v;
         s2_id <= s1_id;
      end
   end

   always_comb begin
      cli.resp_valid = '0;
      if (s2_v) cli.resp_valid[s2_id] = 1'b1;
   end

   assign cli.resp_sum   = s2_v ? add_sum : '0;
   assign cli.resp_carry = s2_v & add_carry;
   assign idle = ~s1_v & ~s2_v & ~gnt_v;

`ifdef ADDER_RR_ARB_PERF_EN
   localparam int CW = $clog2(NUM_REQ + 1);

   logic [CW-1:0] wait_cnt;
   logic [16:0]   wait_sum;

   always_comb begin
      wait_cnt = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         wait_cnt = wait_cnt + CW'(cli.req_valid[i] & ~gnt_oh[i]);
      end
   end

   assign wait_sum = {1'b0, perf_wait} + 17'(wait_cnt);

   // Both counters saturate rather than wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_ops  <= '0;
         perf_wait <= '0;
      end else begin
         if (gnt_v && perf_ops != 16'hFFFF) perf_ops <= perf_ops + 16'd1;
         perf_wait <= wait_sum[16] ? 16'hFFFF : wait_sum[15:0];
      end
   end
`else
   assign perf_ops  = '0;
   assign perf_wait = '0;
`endif

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Directed self-checking bench for adder_rr_arbiter with a 2-cycle registered adder model.
// Perf expectations follow ADDER_RR_ARB_PERF_EN.
module tb_adder_rr_arbiter;
   logic        clk;
   logic        rst;
   logic        hold;
   logic [3:0]  add_a, add_b, add_sum;
   logic        add_carry;
   logic        idle;
   logic [15:0] perf_ops, perf_wait;

   int checks = 0;
   int errors = 0;

   adder_rr_arbiter_if #(.NUM_REQ(4), .WIDTH(4)) ifc ();

   adder_rr_arbiter #(.NUM_REQ(4), .WIDTH(4)) dut (
      .clk(clk), .rst(rst), .hold(hold), .cli(ifc.slave),
      .add_a(add_a), .add_b(add_b), .add_sum(add_sum), .add_carry(add_carry),
      .idle(idle), .perf_ops(perf_ops), .perf_wait(perf_wait)
   );

   // Registered adder: input registers, then sum/carry register.
   logic [3:0] in_a, in_b;
   logic [4:0] out_r;
   always @(posedge clk) begin
      if (rst) begin
         in_a <= '0; in_b <= '0; out_r <= '0;
      end else begin
         in_a <= add_a; in_b <= add_b; out_r <= 5'(in_a) + 5'(in_b);
      end
   end
   assign add_sum = out_r[3:0];
   assign add_carry = out_r[4];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Round-robin operand table: requester i uses a[i], b[i]; sums hand-computed.
   logic [15:0] rr_a = 16'hF731;
   logic [15:0] rr_b = 16'h3A64;
   logic [3:0]  exp_a   [4] = '{4'h1, 4'h3, 4'h7, 4'hF};
   logic [3:0]  exp_b   [4] = '{4'h4, 4'h6, 4'hA, 4'h3};
   logic [3:0]  exp_sum [4] = '{4'h5, 4'h9, 4'h1, 4'h2};
   logic        exp_c   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
   logic [3:0]  one = 4'b0001;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic drive(input logic [3:0] v, input logic [15:0] a, input logic [15:0] b);
      ifc.req_valid = v;
      ifc.req_a = a;
      ifc.req_b = b;
   endtask

   task automatic test_reset();
      tick();
      tick();
      drive(4'b1111, 16'h1234, 16'h5678);
      #1;
      checks++; if (ifc.req_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready: got %b exp 0000", ifc.req_ready); end
      checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rst_idle: got %b exp 1", idle); end
      tick();
      rst = 1'b0;
      drive(4'b0000, 16'h0, 16'h0);
      #1;
      checks++; if (ifc.resp_valid !== 4'b0000) begin errors++; $display("FAIL rst_resp_valid: got %b exp 0000", ifc.resp_valid); end
      checks++; if ({ifc.resp_carry, ifc.resp_sum} !== 5'h00) begin errors++; $display("FAIL rst_resp_data: got %h exp 00", {ifc.resp_carry, ifc.resp_sum}); end
      checks++; if ({add_a, add_b} !== 8'h00) begin errors++; $display("FAIL rst_add_ops: got %h exp 00", {add_a, add_b}); end
      checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rst_idle_after: got %b exp 1", idle); end
      checks++; if ({perf_ops, perf_wait} !== 32'h0) begin errors++; $display("FAIL rst_perf: got %h exp 0", {perf_ops, perf_wait}); end
   endtask

   task automatic test_single();
      tick();
      drive(4'b0100, 16'h0900, 16'h0800);
      #1;
      checks++; if (ifc.req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b exp 0100", ifc.req_ready); end
      checks++; if ({add_a, add_b} !== 8'h98) begin errors++; $display("FAIL single_ops: got %h exp 98", {add_a, add_b}); end
      checks++; if (idle !== 1'b0) begin errors++; $display("FAIL single_idle_grant: got %b exp 0", idle); end
      tick();
      drive(4'b0000, 16'h0, 16'h0);
      #1;
      checks++; if (ifc.resp_valid !== 4'b0000) begin errors++; $display("FAIL single_early_resp: got %b exp 0000", ifc.resp_valid); end
      checks++; if (idle !== 1'b0) begin errors++; $display("FAIL single_idle_s1: got %b exp 0", idle); end
      tick();
      #1;
      checks++; if (ifc.resp_valid !== 4'b0100) begin errors++; $display("FAIL single_resp_valid: got %b exp 0100", ifc.resp_valid); end
      checks++; if (ifc.resp_sum !== 4'h1) begin errors++; $display("FAIL single_sum: got %h exp 1", ifc.resp_sum); end
      checks++; if (ifc.resp_carry !== 1'b1) begin errors++; $display("FAIL single_carry: got %b exp 1", ifc.resp_carry); end
      tick();
      #1;
      checks++; if (ifc.resp_valid !== 4'b0000) begin errors++; $display("FAIL single_resp_width: got %b exp 0000", ifc.resp_valid); end
      checks++; if (idle !== 1'b1) begin errors++; $display("FAIL single_idle_drained: got %b exp 1", idle); end
   endtask

   task automatic test_round_robin();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         if (k > 0) tick();
         drive(4'b1111, rr_a, rr_b);
         #1;
         checks++; if (ifc.req_ready !== (one << (k % 4))) begin errors++; $display("FAIL rr_ready[%0d]: got %b exp %b", k, ifc.req_ready, one << (k % 4)); end
         checks++; if ({add_a, add_b} !== {exp_a[k % 4], exp_b[k % 4]}) begin errors++; $display("FAIL rr_ops[%0d]: got %h exp %h", k, {add_a, add_b}, {exp_a[k % 4], exp_b[k % 4]}); end
         if (k >= 2) begin
            checks++; if (ifc.resp_valid !== (one << ((k - 2) % 4))) begin errors++; $display("FAIL rr_resp_valid[%0d]: got %b exp %b", k, ifc.resp_valid, one << ((k - 2) % 4)); end
            checks++; if ({ifc.resp_carry, ifc.resp_sum} !== {exp_c[(k - 2) % 4], exp_sum[(k - 2) % 4]}) begin errors++; $display("FAIL rr_resp_data[%0d]: got %h exp %h", k, {ifc.resp_carry, ifc.resp_sum}, {exp_c[(k - 2) % 4], exp_sum[(k - 2) % 4]}); end
         end else begin
            checks++; if (ifc.resp_valid !== 4'b0000) begin errors++; $display("FAIL rr_resp_early[%0d]: got %b exp 0000", k, ifc.resp_valid); end
         end
      end
      for (int k = 8; k < 10; k++) begin
         tick();
         drive(4'b0000, 16'h0, 16'h0);
         #1;
         checks++; if (ifc.resp_valid !== (one << ((k - 2) % 4))) begin errors++; $display("FAIL rr_drain_valid[%0d]: got %b exp %b", k, ifc.resp_valid, one << ((k - 2) % 4)); end
         checks++; if ({ifc.resp_carry, ifc.resp_sum} !== {exp_c[(k - 2) % 4], exp_sum[(k - 2) % 4]}) begin errors++; $display("FAIL rr_drain_data[%0d]: got %h exp %h", k, {ifc.resp_carry, ifc.resp_sum}, {exp_c[(k - 2) % 4], exp_sum[(k - 2) % 4]}); end
      end
      tick();
      #1;
      checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rr_idle: got %b exp 1", idle); end
   endtask

   // Last grant was requester 3; requesters 1 and 3 then alternate starting with 1.
   task automatic test_wrap();
      logic [3:0] exp_g [3] = '{4'b0010, 4'b1000, 4'b0010};
      for (int k = 0; k < 3; k++) begin
         tick();
         drive(4'b1010, 16'h5050, 16'h2020);
         #1;
         checks++; if (ifc.req_ready !== exp_g[k]) begin errors++; $display("FAIL wrap_ready[%0d]: got %b exp %b", k, ifc.req_ready, exp_g[k]); end
      end
      tick();
      drive(4'b0000, 16'h0, 16'h0);
      tick();
      tick();
   endtask

   task automatic test_hold();
      tick();
      drive(4'b0001, 16'h0002, 16'h0003);
      #1;
      checks++; if (ifc.req_ready !== 4'b0001) begin errors++; $display("FAIL hold_pre_grant: got %b exp 0001", ifc.req_ready); end
      tick();
      hold = 1'b1;
      #1;
      checks++; if (ifc.req_ready !== 4'b0000) begin errors++; $display("FAIL hold_ready0: got %b exp 0000", ifc.req_ready); end
      checks++; if (idle !== 1'b0) begin errors++; $display("FAIL hold_idle_s1: got %b exp 0", idle); end
      checks++; if ({add_a, add_b} !== 8'h00) begin errors++; $display("FAIL hold_ops: got %h exp 00", {add_a, add_b}); end
      tick();
      #1;
      checks++; if (ifc.resp_valid !== 4'b0001) begin errors++; $display("FAIL hold_resp_valid: got %b exp 0001", ifc.resp_valid); end
      checks++; if ({ifc.resp_carry, ifc.resp_sum} !== 5'h05) begin errors++; $display("FAIL hold_resp_data: got %h exp 05", {ifc.resp_carry, ifc.resp_sum}); end
      checks++; if (ifc.req_ready !== 4'b0000) begin errors++; $display("FAIL hold_ready1: got %b exp 0000", ifc.req_ready); end
      tick();
      #1;
      checks++; if (idle !== 1'b1) begin errors++; $display("FAIL hold_idle_drained: got %b exp 1", idle); end
      checks++; if (ifc.resp_valid !== 4'b0000) begin errors++; $display("FAIL hold_resp_none: got %b exp 0000", ifc.resp_valid); end
      tick();
      hold = 1'b0;
      #1;
      checks++; if (ifc.req_ready !== 4'b0001) begin errors++; $display("FAIL hold_release: got %b exp 0001", ifc.req_ready); end
      tick();
      drive(4'b0000, 16'h0, 16'h0);
      tick();
      tick();
   endtask

   task automatic test_reset_mid();
      tick();
      drive(4'b0100, 16'h050C, 16'h0604);
      #1;
      checks++; if (ifc.req_ready !== 4'b0100) begin errors++; $display("FAIL mid_grant: got %b exp 0100", ifc.req_ready); end
      tick();
      rst = 1'b1;
      drive(4'b1111, 16'h050C, 16'h0604);
      #1;
      checks++; if (ifc.req_ready !== 4'b0000) begin errors++; $display("FAIL mid_rst_ready: got %b exp 0000", ifc.req_ready); end
      checks++; if ({add_a, add_b} !== 8'h00) begin errors++; $display("FAIL mid_rst_ops: got %h exp 00", {add_a, add_b}); end
      tick();
      rst = 1'b0;
      #1;
      checks++; if (ifc.resp_valid !== 4'b0000) begin errors++; $display("FAIL mid_no_resp: got %b exp 0000", ifc.resp_valid); end
      checks++; if ({ifc.resp_carry, ifc.resp_sum} !== 5'h00) begin errors++; $display("FAIL mid_resp_data: got %h exp 00", {ifc.resp_carry, ifc.resp_sum}); end
      checks++; if (ifc.req_ready !== 4'b0001) begin errors++; $display("FAIL mid_first_winner: got %b exp 0001", ifc.req_ready); end
      checks++; if ({add_a, add_b} !== 8'hC4) begin errors++; $display("FAIL mid_ops: got %h exp C4", {add_a, add_b}); end
      tick();
      drive(4'b0000, 16'h0, 16'h0);
      #1;
      checks++; if (ifc.resp_valid !== 4'b0000) begin errors++; $display("FAIL mid_no_resp2: got %b exp 0000", ifc.resp_valid); end
      tick();
      #1;
      checks++; if (ifc.resp_valid !== 4'b0001) begin errors++; $display("FAIL mid_post_valid: got %b exp 0001", ifc.resp_valid); end
      checks++; if ({ifc.resp_carry, ifc.resp_sum} !== 5'h10) begin errors++; $display("FAIL mid_post_data: got %h exp 10", {ifc.resp_carry, ifc.resp_sum}); end
      tick();
   endtask

   task automatic test_perf();
      logic [15:0] exp_ops;
      logic [15:0] exp_wait;
`ifdef ADDER_RR_ARB_PERF_EN
      exp_ops = 16'd10;
      exp_wait = 16'd20;
`else
      exp_ops = 16'd0;
      exp_wait = 16'd0;
`endif
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (k > 0) tick();
         drive(4'b0111, 16'h0321, 16'h0111);
         #1;
         checks++; if (ifc.req_ready !== (one << (k % 3))) begin errors++; $display("FAIL perf_ready[%0d]: got %b exp %b", k, ifc.req_ready, one << (k % 3)); end
      end
      tick();
      drive(4'b0000, 16'h0, 16'h0);
      #1;
      checks++; if (perf_ops !== exp_ops) begin errors++; $display("FAIL perf_ops: got %0d exp %0d", perf_ops, exp_ops); end
      checks++; if (perf_wait !== exp_wait) begin errors++; $display("FAIL perf_wait: got %0d exp %0d", perf_wait, exp_wait); end
      tick();
      tick();
   endtask

   initial begin
      rst = 1'b1;
      hold = 1'b0;
      drive(4'b0000, 16'h0, 16'h0);
      test_reset();
      test_single();
      test_round_robin();
      test_wrap();
      test_hold();
      test_reset_mid();
      test_perf();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/adder_rr_arbiter.md
# adder_rr_arbiter

Round-robin arbiter and sequencer that shares one registered 4-bit adder (2-cycle, register-in/register-out) between NUM_REQ requesters. It grants at most one request per cycle, drives the adder operands and tracks each in-flight operation with a tag pipeline. It returns the sum and carry to the originating requester exactly when the adder output register presents them. It sits between the client blocks and the adder instance, on the adder's clock and reset.

## Interface
- NUM_REQ, default 4: number of requesters, 2..8.
- WIDTH, default 4: operand width; must equal the adder width.
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- hold  in  1  when high, no new grants; in-flight operations still complete.
- req_valid  in  NUM_REQ  per-requester request.
- req_a  in  NUM_REQ*WIDTH  operand A; requester i at bits [i*WIDTH +: WIDTH].
- req_b  in  NUM_REQ*WIDTH  operand B, same packing.
- req_ready  out  NUM_REQ  one-hot or zero grant; handshake = req_valid[i] & req_ready[i].
- add_a, add_b  out  WIDTH  operands to the adder input registers.
- add_sum  in  WIDTH  adder sum register output.
- add_carry  in  1  adder carry register output.
- resp_valid  out  NUM_REQ  one-hot completion strobe, one cycle.
- resp_sum  out  WIDTH  result, valid with resp_valid.
- resp_carry  out  1  carry, valid with resp_valid.
- idle  out  1  high when no operation is in flight and none is granted this cycle.
- perf_ops  out  16  issued-operation count (see Configuration).
- perf_wait  out  16  requester-cycles spent waiting (see Configuration).

## Operation
- Arbitration is combinational from req_valid, hold and the pointer last_gnt. The search starts at (last_gnt+1) mod NUM_REQ and wraps; the first valid requester wins. req_ready is all-zero when hold=1 or rst=1.
- req_ready is never asserted to a requester without req_valid. At most one bit is high.
- On handshake with requester g: last_gnt <= g. add_a/add_b = req_a/req_b slice g in that cycle. Without a grant, add_a/add_b = 0.
- Tag pipeline: s1_v/s1_id <= grant valid/index; s2_v/s2_id <= s1_v/s1_id. It advances every cycle and never stalls.
- resp_valid[s2_id] = s2_v. resp_sum = add_sum and resp_carry = add_carry, passed combinationally. When s2_v=0, resp_valid=0 and resp_sum/resp_carry are driven 0.
- The response has no backpressure: requesters must accept resp_valid in the cycle it is asserted.
- idle = ~s1_v & ~s2_v & ~(|(req_valid & req_ready)).
- Operand arithmetic is performed by the adder. The block passes widths through unmodified; carry is bit WIDTH of A+B.

## Timing
- Handshake in cycle T: resp_valid at cycle T+2, one cycle wide.
- Throughput is one operation per cycle. Back-to-back grants to different or the same requester are legal.
- A requester holding req_valid continuously among N active requesters is granted at least once every N cycles.
- hold rising in cycle T: no grant in T. Grants issued before T still respond at their issue cycle +2.
- Reset values: last_gnt = NUM_REQ-1 (requester 0 has first priority), s1_v = s2_v = 0, req_ready = 0, resp_valid = 0, resp_sum = 0, resp_carry = 0, add_a = add_b = 0, idle = 1, perf_ops = perf_wait = 0.
- Reset mid-operation: in-flight tags are discarded, no resp_valid in the following cycles, and the adder is reset on the same rst.
- Requests that drop req_valid before being granted are simply not granted; no state is kept.

## Configuration
- ADDER_RR_ARB_PERF_EN defined:
  - perf_ops increments on every handshake.
  - perf_wait adds the count of requesters with req_valid & ~req_ready each cycle.
  - Both counters saturate at 16'hFFFF and clear on rst.
- ADDER_RR_ARB_PERF_EN undefined: no counter logic; perf_ops and perf_wait are tied to 0.

## Test plan
- Single request: after reset, req 2 valid with a=4'h9, b=4'h8 for one cycle -> req_ready[2] in that cycle; two cycles later resp_valid=4'b0100, resp_sum=4'h1, resp_carry=1.
- All four requesters valid continuously -> grants 0,1,2,3,0,… one per cycle; responses lag grants by 2 cycles with matching ids and sums.
- Pointer wrap: last grant was 3, then req 1 and req 3 valid -> req 1 granted first.
- hold: hold=1 with req 0 valid -> req_ready=0 and idle=1 once the pipeline drains; the in-flight op from the previous cycle still responds.
- Reset mid-flight: grant at cycle T, rst=1 at T+1 -> no resp_valid at T+2, all outputs at reset values, req 0 wins first after release.
- With ADDER_RR_ARB_PERF_EN: 10 grants with 3 requesters continuously valid -> perf_ops=10 and perf_wait=20; without the macro, both read 0.
